// File: rtl/sp_bram_be.sv
// Single-port byte-enable RAM with selectable read-during-write, optional output stage and clear sweep.
// Latency READ_LATENCY (1 or 2) cycles, one access per cycle; accesses are dropped while init_busy is high.
module sp_bram_be #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    NUM_SETS      = 1024,
  parameter int                    READ_LATENCY  = 1,
  parameter int                    WRITE_MODE    = 0,
  parameter int                    INIT_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         chip_en,
  input  logic [$clog2(NUM_SETS)-1:0]  addr,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH/8-1:0]      wr_be,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         init_req,
  output logic                         init_busy,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_valid
);

  localparam int AW = $clog2(NUM_SETS);
  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic {S_IDLE, S_INIT} state_t;

  state_t                state;
  logic [AW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] mem [NUM_SETS];

  logic                  acc;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged;
  logic                  v1;
  logic [DATA_WIDTH-1:0] d1;

  assign init_busy = (state == S_INIT);
  assign acc       = (state == S_IDLE) && chip_en && !init_req;
  // Only non-power-of-two depths can present an address past the last word.
  assign in_range  = ({1'b0, addr} < (AW+1)'(NUM_SETS));

  always_comb begin
    old_word = '0;
    if (in_range) old_word = mem[addr];
    merged = old_word;
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) merged[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (INIT_ON_RESET != 0) ? S_INIT : S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (init_req) begin
            state <= S_INIT;
            cnt   <= '0;
          end
        end
        S_INIT: begin
          if (cnt == AW'(NUM_SETS - 1)) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array itself carries no reset so it maps onto block RAM with lane enables.
  always_ff @(posedge clk) begin
    if (state == S_INIT && !rst) begin
      mem[cnt] <= INIT_VALUE;
    end else if (acc && wr_en && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= 1'b0;
      if (acc) begin
        if (!wr_en) begin
          v1 <= 1'b1;
          d1 <= old_word;
        end else if (WRITE_MODE == 0) begin
          v1 <= 1'b1;
          d1 <= merged;
        end else if (WRITE_MODE == 1) begin
          v1 <= 1'b1;
          d1 <= old_word;
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  v2;
      logic [DATA_WIDTH-1:0] d2;

      // Drains independently of the sweep FSM so in-flight responses survive init_req.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end

      assign rd_valid = v2;
      assign rd_data  = d2;
    end else begin : g_lat1
      assign rd_valid = v1;
      assign rd_data  = d1;
    end
  endgenerate

endmodule

// File: doc/sp_bram_be.md
Name: sp_bram_be

Overview:
- Next-generation single-port block RAM for cache data/tag arrays and scratchpads.
- Extends the plain single-port BRAM with:
  - per-byte write enables
  - a selectable read-during-write mode
  - an optional output pipeline stage
  - a hardware clear-sweep FSM that initialises every word after reset or on request
- Sits under the cache controllers, which use init_busy to hold off lookups while the array is flushed.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- NUM_SETS, 1024: number of words; need not be a power of two.
- READ_LATENCY, 1: cycles from accepted access to rd_valid; legal values are 1 or 2.
- WRITE_MODE, 0: read-during-write behaviour. 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE.
- INIT_ON_RESET, 1: 1 = run the clear sweep automatically after reset.
- INIT_VALUE, '0: DATA_WIDTH-bit value written to every word by the sweep.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- chip_en  input  1  access request, sampled only when init_busy=0.
- addr  input  $clog2(NUM_SETS)  word address.
- wr_en  input  1  1 = write, 0 = read.
- wr_be  input  DATA_WIDTH/8  byte-lane write enables; bit i covers bits [8i+7:8i].
- wr_data  input  DATA_WIDTH  write data.
- init_req  input  1  single-cycle request to start a clear sweep.
- init_busy  output  1  sweep in progress; accesses are ignored while high.
- rd_data  output  DATA_WIDTH  read data.
- rd_valid  output  1  one-cycle pulse marking rd_data as valid.

Behaviour:
- Reset (async, active-high) values:
  - rd_data='0, rd_valid=0, all pipeline registers cleared.
  - Sweep counter = 0.
  - FSM = INIT if INIT_ON_RESET=1, else IDLE; init_busy mirrors this state during reset.
  - Memory contents are not reset.
- FSM has two states, IDLE and INIT.
  - IDLE -> INIT when init_req=1; init_req has priority over chip_en in the same cycle, and that cycle's access is dropped.
  - INIT: each cycle writes INIT_VALUE to word[cnt], then cnt++.
  - INIT -> IDLE after writing word NUM_SETS-1; cnt returns to 0.
  - init_busy=1 for exactly NUM_SETS cycles; the first access is accepted in the cycle init_busy is seen 0.
  - init_req during INIT is ignored (no restart).
  - Reset asserted mid-sweep restarts from word 0 per INIT_ON_RESET.
- Accepted access: IDLE & chip_en & !init_req.
- Write (wr_en=1):
  - Only lanes with wr_be[i]=1 are updated; other lanes keep their old bytes.
  - wr_be=0 is a legal no-op write but still produces a response per WRITE_MODE.
- Read (wr_en=0): returns word[addr].
- Write response by WRITE_MODE:
  - WRITE_FIRST: rd_data = merged new word, i.e. new bytes in enabled lanes and old bytes elsewhere; rd_valid pulses.
  - READ_FIRST: rd_data = word before the write; rd_valid pulses.
  - NO_CHANGE: rd_data holds, no rd_valid.
- Latency:
  - READ_LATENCY=1: rd_data/rd_valid update on the edge that accepts the access.
  - READ_LATENCY=2: one extra register stage for both rd_data and rd_valid.
  - Fully pipelined, one access per cycle, back-to-back accesses allowed.
- rd_data holds its last value when there is no response; it is never cleared except by reset.
- Out-of-range address (addr >= NUM_SETS, only possible for non-power-of-two depth):
  - Write is dropped.
  - Read returns '0 with rd_valid.
- Sweep writes never produce rd_valid.
- An access to the address being written in the same cycle follows WRITE_MODE exactly; there is no extra forwarding beyond that.
- Responses already in flight in the READ_LATENCY=2 stage drain normally even if a sweep starts.

Test Plan:
- Reset release with INIT_ON_RESET=1, NUM_SETS=16, INIT_VALUE=32'hDEADBEEF -> init_busy high for exactly 16 cycles, then reads of addr 0..15 all return 32'hDEADBEEF with rd_valid 1 cycle after each request.
- Write 32'h11223344 to addr 5, then write 32'hAABBCCDD to addr 5 with wr_be=4'b0101, then read addr 5 -> 32'h11BB33DD.
- WRITE_MODE=1, word[3]=32'h0000FFFF, write 32'h12345678 with wr_be=4'hF -> rd_data=32'h0000FFFF and rd_valid pulses; a following read returns 32'h12345678. With WRITE_MODE=2 the same write leaves rd_data unchanged and gives no rd_valid.
- READ_LATENCY=2, back-to-back reads of addrs 1,2,3 holding 1,2,3 -> rd_valid high for 3 consecutive cycles starting 2 cycles after the first request, with data 1,2,3 in order.
- init_req asserted together with chip_en write to addr 7 -> write dropped and the sweep runs; after init_busy falls, addr 7 reads INIT_VALUE. init_req pulsed again mid-sweep -> busy duration is still exactly NUM_SETS cycles.
- Assert rst at sweep cycle 8 of 16, release -> the sweep restarts at word 0 and init_busy stays high 16 more cycles. NUM_SETS=12: read addr 14 -> rd_data='0 with rd_valid.
